// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-redirect path: default widths and the
// redirect FSM state encoding.
package cpu_pkg;

    localparam int DEF_PC_W         = 10;
    localparam int DEF_FLUSH_CYCLES = 2;
    // Wide enough for the largest legal squash window (7).
    localparam int FLUSH_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } brs_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Compares resolved branch outcomes against fetch's prediction, issues a
// one-cycle redirect on a mispredict and then squashes IF/ID for a fixed window.
module branch_redirect_unit
    import cpu_pkg::*;
#(
    parameter int PC_W         = DEF_PC_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [PC_W-1:0]  br_pc,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_target,
    output logic             predRW,
    output logic [PC_W-1:0]  PCnext,
    output logic             squash,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    brs_state_t             state, state_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
    logic                   predRW_nxt, squash_nxt;
    logic [PC_W-1:0]        PCnext_nxt;

    logic                   accept;
    logic                   mispred;
    logic [PC_W-1:0]        correct_pc;

    // Anything arriving outside IDLE is wrong-path and must not be counted.
    assign accept     = br_valid && (state == IDLE);
    assign mispred    = (br_taken != pred_taken) ||
                        (br_taken && pred_taken && (br_target != pred_target));
    assign correct_pc = br_taken ? br_target : br_pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            predRW    <= 1'b0;
            squash    <= 1'b0;
            PCnext    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            predRW    <= predRW_nxt;
            squash    <= squash_nxt;
            PCnext    <= PCnext_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        predRW_nxt    = 1'b0;
        squash_nxt    = squash;
        PCnext_nxt    = PCnext;
        case (state)
            IDLE: begin
                squash_nxt = 1'b0;
                if (accept && mispred) begin
                    state_nxt  = REDIRECT;
                    PCnext_nxt = correct_pc;
                    predRW_nxt = 1'b1;
                    squash_nxt = 1'b1;
                end
            end
            REDIRECT: begin
                state_nxt     = FLUSH;
                flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                squash_nxt    = 1'b1;
            end
            FLUSH: begin
                squash_nxt = 1'b1;
                if (flush_cnt == '0) begin
                    state_nxt  = IDLE;
                    squash_nxt = 1'b0;
                end else begin
                    flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                squash_nxt = 1'b0;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .count (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && mispred),
        .count (mispred_count)
    );

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit; a second narrow-counter instance
// shares the stimulus so saturation is reachable in a short run.
module tb_branch_redirect_unit;

    localparam int PC_W = 10;
    localparam int CNT_W = 16;
    localparam int SCNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             br_valid = 1'b0;
    logic [PC_W-1:0]  br_pc = '0;
    logic             br_taken = 1'b0;
    logic [PC_W-1:0]  br_target = '0;
    logic             pred_taken = 1'b0;
    logic [PC_W-1:0]  pred_target = '0;
    logic             predRW, squash, busy;
    logic [PC_W-1:0]  PCnext;
    logic [CNT_W-1:0] branch_count, mispred_count;
    logic             s_predRW, s_squash, s_busy;
    logic [PC_W-1:0]  s_PCnext;
    logic [SCNT_W-1:0] s_branch_count, s_mispred_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    branch_redirect_unit #(.PC_W(PC_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_pc(br_pc),
        .br_taken(br_taken), .br_target(br_target), .pred_taken(pred_taken),
        .pred_target(pred_target), .predRW(predRW), .PCnext(PCnext),
        .squash(squash), .busy(busy), .branch_count(branch_count),
        .mispred_count(mispred_count)
    );

    branch_redirect_unit #(.PC_W(PC_W), .FLUSH_CYCLES(2), .CNT_W(SCNT_W)) dut_small (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_pc(br_pc),
        .br_taken(br_taken), .br_target(br_target), .pred_taken(pred_taken),
        .pred_target(pred_target), .predRW(s_predRW), .PCnext(s_PCnext),
        .squash(s_squash), .busy(s_busy), .branch_count(s_branch_count),
        .mispred_count(s_mispred_count)
    );

    // Called at a negedge: presents one branch for the next posedge and
    // returns at the following negedge, where the registered result is visible.
    task automatic issue(input logic [PC_W-1:0] pc, input logic tk,
                         input logic [PC_W-1:0] tgt, input logic ptk,
                         input logic [PC_W-1:0] ptgt);
        br_valid = 1'b1; br_pc = pc; br_taken = tk; br_target = tgt;
        pred_taken = ptk; pred_target = ptgt;
        @(negedge clk);
        br_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (predRW !== 1'b0) begin bad++; $display("FAIL reset_predRW got=%b exp=0", predRW); end
        total++; if (squash !== 1'b0) begin bad++; $display("FAIL reset_squash got=%b exp=0", squash); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (PCnext !== 10'h000) begin bad++; $display("FAIL reset_PCnext got=%h exp=000", PCnext); end
        total++; if (branch_count !== 16'd0 || mispred_count !== 16'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispred_count); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_correct_pred;
        issue(10'h010, 1'b0, 10'h000, 1'b0, 10'h000);
        total++; if (predRW !== 1'b0 || squash !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL correct_outputs got=%b%b%b exp=000", predRW, squash, busy); end
        total++; if (branch_count !== 16'd1 || mispred_count !== 16'd0) begin
            bad++; $display("FAIL correct_counts got=%0d/%0d exp=1/0", branch_count, mispred_count); end
        @(negedge clk);
        total++; if (predRW !== 1'b0 || squash !== 1'b0) begin
            bad++; $display("FAIL correct_later got=%b%b exp=00", predRW, squash); end
    endtask

    task automatic test_taken_mispred;
        issue(10'h020, 1'b1, 10'h080, 1'b0, 10'h000);
        total++; if (predRW !== 1'b1 || squash !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL tk_redirect got=%b%b%b exp=111", predRW, squash, busy); end
        total++; if (PCnext !== 10'h080) begin bad++; $display("FAIL tk_PCnext got=%h exp=080", PCnext); end
        total++; if (branch_count !== 16'd2 || mispred_count !== 16'd1) begin
            bad++; $display("FAIL tk_counts got=%0d/%0d exp=2/1", branch_count, mispred_count); end
        @(negedge clk);
        total++; if (predRW !== 1'b0 || squash !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL tk_flush1 got=%b%b%b exp=011", predRW, squash, busy); end
        @(negedge clk);
        total++; if (predRW !== 1'b0 || squash !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL tk_flush2 got=%b%b%b exp=011", predRW, squash, busy); end
        @(negedge clk);
        total++; if (squash !== 1'b0 || busy !== 1'b0 || PCnext !== 10'h080) begin
            bad++; $display("FAIL tk_idle got sq=%b busy=%b pc=%h exp sq=0 busy=0 pc=080", squash, busy, PCnext); end
    endtask

    task automatic test_wrap;
        issue(10'h3FF, 1'b0, 10'h000, 1'b1, 10'h123);
        total++; if (predRW !== 1'b1 || PCnext !== 10'h000) begin
            bad++; $display("FAIL wrap_redirect got rw=%b pc=%h exp rw=1 pc=000", predRW, PCnext); end
        @(negedge clk);
        total++; if (predRW !== 1'b0) begin bad++; $display("FAIL wrap_pulse got=%b exp=0", predRW); end
        repeat (2) @(negedge clk);
        total++; if (squash !== 1'b0 || mispred_count !== 16'd2) begin
            bad++; $display("FAIL wrap_idle got sq=%b mp=%0d exp sq=0 mp=2", squash, mispred_count); end
    endtask

    task automatic test_target_mismatch;
        issue(10'h030, 1'b1, 10'h044, 1'b1, 10'h040);
        total++; if (predRW !== 1'b1 || PCnext !== 10'h044) begin
            bad++; $display("FAIL tgt_redirect got rw=%b pc=%h exp rw=1 pc=044", predRW, PCnext); end
        // Wrong-path mispredicts presented across the REDIRECT and FLUSH cycles.
        br_valid = 1'b1; br_pc = 10'h050; br_taken = 1'b0; pred_taken = 1'b1;
        @(negedge clk);
        total++; if (predRW !== 1'b0 || squash !== 1'b1) begin
            bad++; $display("FAIL tgt_ignore1 got rw=%b sq=%b exp rw=0 sq=1", predRW, squash); end
        @(negedge clk);
        br_valid = 1'b0;
        total++; if (predRW !== 1'b0 || PCnext !== 10'h044) begin
            bad++; $display("FAIL tgt_ignore2 got rw=%b pc=%h exp rw=0 pc=044", predRW, PCnext); end
        @(negedge clk);
        total++; if (branch_count !== 16'd4 || mispred_count !== 16'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL tgt_counts got=%0d/%0d busy=%b exp=4/3 busy=0", branch_count, mispred_count, busy); end
    endtask

    task automatic test_back_to_back;
        issue(10'h100, 1'b0, 10'h000, 1'b1, 10'h0F0);
        total++; if (PCnext !== 10'h101 || predRW !== 1'b1) begin
            bad++; $display("FAIL b2b_first got rw=%b pc=%h exp rw=1 pc=101", predRW, PCnext); end
        repeat (2) @(negedge clk);
        // Held over the last FLUSH edge (ignored) and the first IDLE edge (accepted).
        br_valid = 1'b1; br_pc = 10'h200; br_taken = 1'b1; br_target = 10'h2AA; pred_taken = 1'b0;
        @(negedge clk);
        total++; if (predRW !== 1'b0 || busy !== 1'b0 || branch_count !== 16'd5) begin
            bad++; $display("FAIL b2b_lastflush got rw=%b busy=%b br=%0d exp rw=0 busy=0 br=5", predRW, busy, branch_count); end
        @(negedge clk);
        br_valid = 1'b0;
        total++; if (predRW !== 1'b1 || PCnext !== 10'h2AA || mispred_count !== 16'd5 || branch_count !== 16'd6) begin
            bad++; $display("FAIL b2b_second got rw=%b pc=%h cnt=%0d/%0d exp rw=1 pc=2AA cnt=6/5",
                            predRW, PCnext, branch_count, mispred_count); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_flush;
        issue(10'h010, 1'b1, 10'h155, 1'b0, 10'h000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (squash !== 1'b0 || predRW !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%b%b%b exp=000", predRW, squash, busy); end
        total++; if (branch_count !== 16'd0 || mispred_count !== 16'd0 || PCnext !== 10'h000) begin
            bad++; $display("FAIL rstmid_state got=%0d/%0d pc=%h exp=0/0 pc=000", branch_count, mispred_count, PCnext); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++; if (predRW !== 1'b0 || squash !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rstmid_after got=%b%b%b exp=000", predRW, squash, busy); end
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 17; i++) begin
            issue(10'(i), 1'b1, 10'h300, 1'b0, 10'h000);
            repeat (3) @(negedge clk);
        end
        total++; if (s_mispred_count !== 4'hF || s_branch_count !== 4'hF) begin
            bad++; $display("FAIL sat_small got=%h/%h exp=F/F", s_branch_count, s_mispred_count); end
        total++; if (branch_count !== 16'd17 || mispred_count !== 16'd17) begin
            bad++; $display("FAIL sat_wide got=%0d/%0d exp=17/17", branch_count, mispred_count); end
        issue(10'h040, 1'b0, 10'h000, 1'b0, 10'h000);
        total++; if (s_branch_count !== 4'hF || branch_count !== 16'd18 || s_predRW !== 1'b0) begin
            bad++; $display("FAIL sat_hold got=%h wide=%0d rw=%b exp=F wide=18 rw=0", s_branch_count, branch_count, s_predRW); end
        total++; if (s_PCnext !== 10'h300 || s_squash !== 1'b0 || s_busy !== 1'b0) begin
            bad++; $display("FAIL sat_small_state got pc=%h sq=%b busy=%b exp pc=300 sq=0 busy=0", s_PCnext, s_squash, s_busy); end
    endtask

    initial begin
        test_reset;
        test_correct_pred;
        test_taken_mispred;
        test_wrap;
        test_target_mismatch;
        test_back_to_back;
        test_reset_mid_flush;
        test_saturation;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumer-side end of the fetch redirect interface. Sits after decode/execute and receives resolved branch/jump outcomes together with the prediction fetch made for them.
- On a misprediction it drives predRW/PCnext back to instruction fetch for exactly one cycle.
- It then squashes wrong-path bundles already in flight in IF/ID for a fixed window.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- PC_W, 10, PC width; matches the instruction ROM address width.
- FLUSH_CYCLES, 2, cycles squash stays high after the redirect cycle. Legal range 1..7.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- br_valid  input  1  resolved control-flow op presented this cycle
- br_pc  input  PC_W  PC of the bundle holding the branch
- br_taken  input  1  actual outcome
- br_target  input  PC_W  actual target (valid when br_taken=1)
- pred_taken  input  1  fetch's prediction (jump-predictor hit) for this bundle
- pred_target  input  PC_W  target fetch used when pred_taken=1
- predRW  output  1  redirect request to fetch; fetch loads PCnext when high
- PCnext  output  PC_W  corrected fetch PC
- squash  output  1  invalidate IF/ID bundles this cycle
- busy  output  1  state != IDLE
- branch_count  output  CNT_W  accepted resolutions, saturating
- mispred_count  output  CNT_W  detected mispredictions, saturating

Behaviour:
- Reset (async): state=IDLE; predRW=0, PCnext=0, squash=0, busy=0, both counters=0. Reset mid-REDIRECT/FLUSH aborts immediately; no redirect is issued after release.
- All outputs are registered. No combinational path from inputs to outputs.
- Mispredict (combinational on inputs): (br_taken != pred_taken) OR (br_taken AND pred_taken AND br_target != pred_target).
- Correct PC: br_taken ? br_target : br_pc + 1, truncated to PC_W. Wraps, e.g. 10'h3FF -> 10'h000.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE:
  - br_valid=1 is accepted: branch_count += 1 (saturate at all-ones).
  - If it mispredicts: mispred_count += 1 (saturate); next state REDIRECT; PCnext <= correct PC; predRW <= 1; squash <= 1.
  - Otherwise: stay in IDLE with no outputs asserted.
  - br_valid=0: hold.
- REDIRECT (exactly 1 cycle; latency is 1 cycle from the br_valid edge to predRW=1):
  - predRW=1, squash=1.
  - Next state FLUSH; load flush counter = FLUSH_CYCLES-1; predRW <= 0.
  - PCnext holds its value until the next redirect; it is never cleared except by reset.
- FLUSH:
  - squash=1, predRW=0.
  - Counter decrements each cycle. When it is 0, go to IDLE and squash <= 0.
  - Total squash duration = 1 + FLUSH_CYCLES cycles.
- br_valid during REDIRECT or FLUSH is wrong-path: ignored entirely. No count, no redirect, no state change.
- Back-to-back: a mispredict in the first IDLE cycle after FLUSH is accepted normally.
- Correctly predicted branches never touch predRW or squash.
- busy=1 in REDIRECT and FLUSH.

Decomposition:
- Shared package cpu_pkg: PC_W, FLUSH_CYCLES default, state enum brs_state_t {IDLE, REDIRECT, FLUSH}.
- Sub-module sat_counter (parameter CNT_W, inc, count), instantiated twice for the statistics.
- FSM, mispredict compare and next-PC mux stay in the top module.

Test Plan:
- Not-taken predicted not-taken: br_valid=1, br_pc=10'h010, br_taken=0, pred_taken=0 -> predRW stays 0, squash 0, branch_count=1, mispred_count=0.
- Taken, predicted not-taken: br_pc=10'h020, br_target=10'h080, pred_taken=0 -> next cycle predRW=1, PCnext=10'h080, squash=1. Then squash stays high 2 more cycles (FLUSH_CYCLES=2), then IDLE; mispred_count=1.
- Predicted taken, actually not taken, at br_pc=10'h3FF -> PCnext=10'h000 (wrap), predRW one-cycle pulse.
- Target mismatch: pred_taken=1, pred_target=10'h040, br_taken=1, br_target=10'h044 -> redirect to 10'h044. Further br_valid mispredicts during the squash window -> ignored, mispred_count unchanged, no second predRW.
- Assert rst_n=0 in the FLUSH cycle -> squash/predRW/busy=0 and counters=0 immediately. After release, IDLE with no spurious redirect.
- Preload counters near saturation via 65535 accepted mispredicts (CNT_W=16) -> both counters hold 16'hFFFF on further events.
